traffic_phase_scheduler: RTL and testbench



---
 rtl/traffic_phase_scheduler_if.sv | 33 +++
 rtl/traffic_phase_scheduler.sv | 142 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if
// Groups the sensor/request inputs and the light outputs of the intersection
// phase scheduler.
//   tick     one-cycle timebase strobe
//   x        country-road vehicle sensor (level)
//   ped_req  pedestrian request
//   emerg    emergency preempt (level), grants highway
//   highway  highway light code, red=100 yellow=010 green=001
//   country  country light code, same encoding
//   walk     pedestrian walk indication
//   phase    current phase code
// master: drives the inputs (bench / upstream logic)
// slave : the scheduler itself
interface traffic_phase_scheduler_if;
    logic       tick;
    logic       x;
    logic       ped_req;
    logic       emerg;
    logic [2:0] highway;
    logic [2:0] country;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output tick, x, ped_req, emerg,
        input  highway, country, walk, phase
    );

    modport slave (
        input  tick, x, ped_req, emerg,
        output highway, country, walk, phase
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Sequences the highway and country light heads through green, yellow and
// all-red phases using tick-based dwell timers, with pedestrian and
// emergency-preempt handling. Light codes, walk and phase are registered.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset (forces HG immediately)
//   bus  traffic_phase_scheduler_if.slave: tick/x/ped_req/emerg in,
//        highway/country/walk/phase out
module traffic_phase_scheduler #(
    parameter int GREEN_MIN     = 8,
    parameter int COUNTRY_GREEN = 10,
    parameter int GREEN_MAX     = 32,
    parameter int YELLOW        = 3,
    parameter int ALLRED        = 2,
    parameter int CNT_W         = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    traffic_phase_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] GMIN_L = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] CGRN_L = CNT_W'(COUNTRY_GREEN - 1);
    localparam logic [CNT_W-1:0] GMAX_L = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_L  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_L   = CNT_W'(ALLRED - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_limit;
    logic             ped_pend, ped_pend_next;
    logic [2:0]       highway_q, country_q, highway_d, country_d;
    logic             walk_q, walk_d;

    // State, timer, pending request and the registered light outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HG;
            cnt       <= '0;
            ped_pend  <= 1'b0;
            highway_q <= 3'b001;
            country_q <= 3'b100;
            walk_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ped_pend  <= ped_pend_next;
            highway_q <= highway_d;
            country_q <= country_d;
            walk_q    <= walk_d;
        end
    end

    // Next phase, timer and pedestrian latch. Every transition needs a tick;
    // only HG can dwell past its limit, so the timer saturates there to hold
    // the minimum-green-satisfied condition indefinitely.
    always_comb begin
        state_next = state;
        cnt_limit  = '0;
        case (state)
            HG: begin
                cnt_limit = GMIN_L;
                if (bus.tick && cnt >= GMIN_L && (bus.x || ped_pend) && !bus.emerg)
                    state_next = HY;
            end
            HY: begin
                cnt_limit = YEL_L;
                if (bus.tick && cnt == YEL_L)
                    state_next = AR1;
            end
            AR1: begin
                cnt_limit = AR_L;
                if (bus.tick && cnt == AR_L)
                    state_next = bus.emerg ? HG : CG;
            end
            CG: begin
                cnt_limit = GMAX_L;
                if (bus.tick && (bus.emerg || (cnt >= CGRN_L && !bus.x) || cnt == GMAX_L))
                    state_next = CY;
            end
            CY: begin
                cnt_limit = YEL_L;
                if (bus.tick && cnt == YEL_L)
                    state_next = AR2;
            end
            AR2: begin
                cnt_limit = AR_L;
                if (bus.tick && cnt == AR_L)
                    state_next = HG;
            end
            default: state_next = HG;
        endcase

        if (state_next != state)
            cnt_next = '0;
        else if (bus.tick && cnt < cnt_limit)
            cnt_next = cnt + 1'b1;
        else
            cnt_next = cnt;

        // Granting country green serves the request; that clear beats a new one.
        if (state == AR1 && state_next == CG)
            ped_pend_next = 1'b0;
        else if (bus.ped_req && state != CG)
            ped_pend_next = 1'b1;
        else
            ped_pend_next = ped_pend;
    end

    // Light codes are decoded from the next phase so they register on the
    // same edge as the phase itself.
    always_comb begin
        highway_d = 3'b100;
        country_d = 3'b100;
        walk_d    = 1'b0;
        case (state_next)
            HG: highway_d = 3'b001;
            HY: highway_d = 3'b010;
            CG: begin
                country_d = 3'b001;
                walk_d    = 1'b1;
            end
            CY: country_d = 3'b010;
            default: ;
        endcase
    end

    assign bus.highway = highway_q;
    assign bus.country = country_q;
    assign bus.walk    = walk_q;
    assign bus.phase   = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler
// Drives the phase scheduler through directed scenarios and a randomized run,
// comparing every cycle against a tick-counting reference model and checking
// phase lengths against fixed expected durations.
module tb_traffic_phase_scheduler;

    localparam int GREEN_MIN     = 8;
    localparam int COUNTRY_GREEN = 10;
    localparam int GREEN_MAX     = 32;
    localparam int YELLOW        = 3;
    localparam int ALLRED        = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .GREEN_MIN(GREEN_MIN),
        .COUNTRY_GREEN(COUNTRY_GREEN),
        .GREEN_MAX(GREEN_MAX),
        .YELLOW(YELLOW),
        .ALLRED(ALLRED),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: phase index, ticks spent in the phase, pending walk.
    int mPhase;
    int mElapsed;
    bit mPed;
    int hwTab [6] = '{1, 2, 4, 4, 4, 4};
    int ctTab [6] = '{4, 4, 4, 1, 2, 4};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tickEvery = 1;

    function automatic void modelReset();
        mPhase   = 0;
        mElapsed = 0;
        mPed     = 1'b0;
    endfunction

    // One clock edge of the scheduling rules, counted in whole ticks.
    function automatic void modelStep(input logic t, input logic xx, input logic p, input logic e);
        bit leave;
        int nxt;
        int done;
        leave = 1'b0;
        nxt   = (mPhase + 1) % 6;
        done  = mElapsed + 1;
        if (t) begin
            case (mPhase)
                0: leave = (done >= GREEN_MIN) && (xx || mPed) && !e;
                1, 4: leave = (done == YELLOW);
                2: begin
                    leave = (done == ALLRED);
                    if (e) nxt = 0;
                end
                3: leave = e || (done >= COUNTRY_GREEN && !xx) || (done == GREEN_MAX);
                default: leave = (done == ALLRED);
            endcase
        end
        if (leave && mPhase == 2 && nxt == 3)
            mPed = 1'b0;
        else if (p && mPhase != 3)
            mPed = 1'b1;
        if (leave) begin
            mPhase   = nxt;
            mElapsed = 0;
        end else if (t) begin
            mElapsed++;
        end
    endfunction

    task automatic checkOutput(input string tag);
        checks++;
        assert (bus.phase === 3'(mPhase)) else begin
            failures++;
            $error("FAIL %s phase: observed=%0d expected=%0d", tag, bus.phase, mPhase);
        end
        checks++;
        assert (bus.highway === 3'(hwTab[mPhase])) else begin
            failures++;
            $error("FAIL %s highway: observed=%b expected=%b", tag, bus.highway, 3'(hwTab[mPhase]));
        end
        checks++;
        assert (bus.country === 3'(ctTab[mPhase])) else begin
            failures++;
            $error("FAIL %s country: observed=%b expected=%b", tag, bus.country, 3'(ctTab[mPhase]));
        end
        checks++;
        assert (bus.walk === (mPhase == 3)) else begin
            failures++;
            $error("FAIL %s walk: observed=%b expected=%b", tag, bus.walk, (mPhase == 3));
        end
    endtask

    // Called just after an active edge; drives inputs for the next edge.
    task automatic applyStimulus(input logic t, input logic xx, input logic p, input logic e,
                                 input string tag);
        bus.tick    = t;
        bus.x       = xx;
        bus.ped_req = p;
        bus.emerg   = e;
        @(posedge clk);
        modelStep(t, xx, p, e);
        #1;
        cyc++;
        checkOutput(tag);
    endtask

    task automatic stepTimed(input logic xx, input logic p, input logic e, input string tag);
        applyStimulus((cyc % tickEvery) == tickEvery - 1, xx, p, e, tag);
    endtask

    task automatic measurePhase(input string tag, input int expPhase, input int expLen,
                                input logic xx, input logic p, input logic e);
        int n;
        n = 0;
        checks++;
        assert (bus.phase === 3'(expPhase)) else begin
            failures++;
            $error("FAIL %s entry: observed=%0d expected=%0d", tag, bus.phase, expPhase);
        end
        while (bus.phase === 3'(expPhase) && n < 2000) begin
            stepTimed(xx, p, e, tag);
            n++;
        end
        checks++;
        assert (n == expLen) else begin
            failures++;
            $error("FAIL %s length: observed=%0d expected=%0d", tag, n, expLen);
        end
    endtask

    task automatic doReset();
        rst         = 1'b1;
        bus.tick    = 1'b0;
        bus.x       = 1'b0;
        bus.ped_req = 1'b0;
        bus.emerg   = 1'b0;
        modelReset();
        #2;
        checkOutput("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic rx, re;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Idle: no demand keeps highway green.
        tickEvery = 1;
        doReset();
        for (int i = 0; i < 100; i++) stepTimed(1'b0, 1'b0, 1'b0, "idle");
        checks++;
        assert (bus.phase === 3'd0 && bus.highway === 3'b001 && bus.walk === 1'b0) else begin
            failures++;
            $error("FAIL idleEnd: observed=%0d/%b expected=0/001", bus.phase, bus.highway);
        end

        // Continuous country demand: full cycle with max-green cap.
        doReset();
        measurePhase("xHG", 0, 8, 1'b1, 1'b0, 1'b0);
        measurePhase("xHY", 1, 3, 1'b1, 1'b0, 1'b0);
        measurePhase("xAR1", 2, 2, 1'b1, 1'b0, 1'b0);
        measurePhase("xCG", 3, 32, 1'b1, 1'b0, 1'b0);
        measurePhase("xCY", 4, 3, 1'b1, 1'b0, 1'b0);
        measurePhase("xAR2", 5, 2, 1'b1, 1'b0, 1'b0);
        measurePhase("xHG2", 0, 8, 1'b1, 1'b0, 1'b0);

        // Pedestrian request alone gives one minimum country green.
        doReset();
        for (int i = 0; i < 3; i++) stepTimed(1'b0, 1'b0, 1'b0, "pedPre");
        stepTimed(1'b0, 1'b1, 1'b0, "pedPulse");
        measurePhase("pHG", 0, 4, 1'b0, 1'b0, 1'b0);
        measurePhase("pHY", 1, 3, 1'b0, 1'b0, 1'b0);
        measurePhase("pAR1", 2, 2, 1'b0, 1'b0, 1'b0);
        measurePhase("pCG", 3, 10, 1'b0, 1'b0, 1'b0);
        measurePhase("pCY", 4, 3, 1'b0, 1'b0, 1'b0);
        measurePhase("pAR2", 5, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) stepTimed(1'b0, 1'b0, 1'b0, "pedHold");
        checks++;
        assert (bus.phase === 3'd0) else begin
            failures++;
            $error("FAIL pedHoldEnd: observed=%0d expected=0", bus.phase);
        end

        // Emergency during country green.
        doReset();
        measurePhase("eHG", 0, 8, 1'b1, 1'b0, 1'b0);
        measurePhase("eHY", 1, 3, 1'b1, 1'b0, 1'b0);
        measurePhase("eAR1", 2, 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) stepTimed(1'b1, 1'b0, 1'b0, "eCGpre");
        measurePhase("eCG", 3, 1, 1'b1, 1'b0, 1'b1);
        measurePhase("eCY", 4, 3, 1'b1, 1'b0, 1'b1);
        measurePhase("eAR2", 5, 2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) stepTimed(1'b1, 1'b0, 1'b1, "eHold");
        measurePhase("eRelease", 0, 1, 1'b1, 1'b0, 1'b0);
        measurePhase("eHY2", 1, 3, 1'b1, 1'b0, 1'b0);

        // Sparse ticks: every duration scales by four.
        tickEvery = 4;
        doReset();
        measurePhase("sHG", 0, 32, 1'b1, 1'b0, 1'b0);
        measurePhase("sHY", 1, 12, 1'b1, 1'b0, 1'b0);
        measurePhase("sAR1", 2, 8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 48; i++) stepTimed(1'b1, 1'b0, 1'b0, "sCGpre");
        measurePhase("sCG", 3, 4, 1'b0, 1'b0, 1'b0);
        measurePhase("sCY", 4, 12, 1'b0, 1'b0, 1'b0);
        measurePhase("sAR2", 5, 8, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of country yellow.
        tickEvery = 1;
        doReset();
        measurePhase("rHG", 0, 8, 1'b1, 1'b0, 1'b0);
        measurePhase("rHY", 1, 3, 1'b1, 1'b0, 1'b0);
        measurePhase("rAR1", 2, 2, 1'b1, 1'b0, 1'b0);
        measurePhase("rCG", 3, 32, 1'b1, 1'b0, 1'b0);
        stepTimed(1'b1, 1'b0, 1'b0, "rCY");
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midReset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        measurePhase("rHGafter", 0, 8, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        doReset();
        rx = 1'b0;
        re = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) rx = ~rx;
            if ($urandom_range(0, 99) == 0) re = ~re;
            applyStimulus($urandom_range(0, 2) != 0, rx, $urandom_range(0, 29) == 0, re, "random");
        end

        $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
